// File: rtl/hack_alu_pkg.sv
// hack_alu_pkg
// Shared definitions for the pipelined Hack ALU.
//   - The 18 canonical Hack control encodings, packed as {zx,nx,zy,ny,f,no}.
//   - s1_ctl_t: the control bits that travel with stage-1 operands into
//     stage 2. zx/nx/zy/ny are consumed by stage 1 and are not carried.
package hack_alu_pkg;

    localparam logic [5:0] ZERO    = 6'b101010;
    localparam logic [5:0] ONE     = 6'b111111;
    localparam logic [5:0] NEG_ONE = 6'b111010;
    localparam logic [5:0] X       = 6'b001100;
    localparam logic [5:0] Y       = 6'b110000;
    localparam logic [5:0] NOT_X   = 6'b001101;
    localparam logic [5:0] NOT_Y   = 6'b110001;
    localparam logic [5:0] NEG_X   = 6'b001111;
    localparam logic [5:0] NEG_Y   = 6'b110011;
    localparam logic [5:0] X_INC   = 6'b011111;
    localparam logic [5:0] Y_INC   = 6'b110111;
    localparam logic [5:0] X_DEC   = 6'b001110;
    localparam logic [5:0] Y_DEC   = 6'b110010;
    localparam logic [5:0] X_ADD_Y = 6'b000010;
    localparam logic [5:0] X_SUB_Y = 6'b010011;
    localparam logic [5:0] Y_SUB_X = 6'b000111;
    localparam logic [5:0] X_AND_Y = 6'b000000;
    localparam logic [5:0] X_OR_Y  = 6'b010101;

    typedef struct packed {
        logic f;
        logic no;
    } s1_ctl_t;

endpackage

// File: rtl/hack_alu_core.sv
// hack_alu_core
// Combinational stage-2 datapath of the pipelined Hack ALU.
// Ports:
//   xp, yp  (in,  WIDTH) preset operands from stage 1
//   f, no   (in,  1)     add/and select, output invert
//   out     (out, WIDTH) result after the optional inversion
//   zr, ng  (out, 1)     out == 0, out MSB
//   co, ov  (out, 1)     adder carry / signed overflow, taken before the
//                        inversion; 0 for AND or when FLAG_EXT == 0
module hack_alu_core #(
    parameter int WIDTH    = 16,
    parameter int FLAG_EXT = 1
) (
    input  logic [WIDTH-1:0] xp,
    input  logic [WIDTH-1:0] yp,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             add_ov;

    // One extra bit on the adder exposes the carry; the low WIDTH bits wrap.
    assign sum    = {1'b0, xp} + {1'b0, yp};
    assign r      = f ? sum[WIDTH-1:0] : (xp & yp);
    assign out    = no ? ~r : r;
    assign zr     = (out == '0);
    assign ng     = out[WIDTH-1];

    // Overflow: operands agree in sign but the wrapped sum does not.
    assign add_ov = (xp[WIDTH-1] == yp[WIDTH-1]) && (sum[WIDTH-1] != xp[WIDTH-1]);

    generate
        if (FLAG_EXT != 0) begin : g_flags
            assign co = f & sum[WIDTH];
            assign ov = f & add_ov;
        end else begin : g_no_flags
            assign co = 1'b0;
            assign ov = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe
// Two-stage valid/ready pipelined Hack ALU.
//   Stage 1 registers the preset operands (zx/nx, zy/ny applied) plus f/no.
//   Stage 2 registers out and the zr/ng/co/ov flags from hack_alu_core.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   x, y      (in, WIDTH) operands
//   zx..no    (in, 1)     Hack control bits
//   in_valid / in_ready   input handshake
//   out_valid / out_ready output handshake
//   out       (out,WIDTH) result; zr, ng, co, ov result flags
// Handshake: a beat moves on a rising edge where valid && ready are both
// high. in_ready depends on out_ready and internal state only, never on
// in_valid. Outputs hold stable while out_valid && !out_ready.
module hack_alu_pipe #(
    parameter int WIDTH    = 16,
    parameter int FLAG_EXT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);

    import hack_alu_pkg::*;

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_xp;
    logic [WIDTH-1:0] s1_yp;
    s1_ctl_t          s1_ctl;

    // Stage 2 state
    logic             s2_valid;

    // Preset logic ahead of the stage-1 register
    logic [WIDTH-1:0] x_zero;
    logic [WIDTH-1:0] y_zero;
    logic [WIDTH-1:0] xp_next;
    logic [WIDTH-1:0] yp_next;

    // Core outputs
    logic [WIDTH-1:0] core_out;
    logic             core_zr;
    logic             core_ng;
    logic             core_co;
    logic             core_ov;

    logic             s2_load;
    logic             s1_adv;

    assign x_zero  = zx ? '0 : x;
    assign xp_next = nx ? ~x_zero : x_zero;
    assign y_zero  = zy ? '0 : y;
    assign yp_next = ny ? ~y_zero : y_zero;

    // Stage 2 takes a new beat when empty or when its current beat leaves;
    // stage 1 advances when empty or when it hands its beat to stage 2.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_load;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_xp    <= '0;
            s1_yp    <= '0;
            s1_ctl   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_xp     <= xp_next;
                s1_yp     <= yp_next;
                s1_ctl.f  <= f;
                s1_ctl.no <= no;
            end
        end
    end

    hack_alu_core #(
        .WIDTH    (WIDTH),
        .FLAG_EXT (FLAG_EXT)
    ) u_core (
        .xp  (s1_xp),
        .yp  (s1_yp),
        .f   (s1_ctl.f),
        .no  (s1_ctl.no),
        .out (core_out),
        .zr  (core_zr),
        .ng  (core_ng),
        .co  (core_co),
        .ov  (core_ov)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out      <= '0;
            zr       <= 1'b0;
            ng       <= 1'b0;
            co       <= 1'b0;
            ov       <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            // Result registers only change on a real beat, so a bubble
            // leaves the last result visible (with out_valid low).
            if (s1_valid) begin
                out <= core_out;
                zr  <= core_zr;
                ng  <= core_ng;
                co  <= core_co;
                ov  <= core_ov;
            end
        end
    end

endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb_hack_alu_pipe
// Bench for hack_alu_pipe at WIDTH 16 (main), 8 and 32 (corner cases).
module tb_hack_alu_pipe;
    import hack_alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- WIDTH=16 DUT ----------------
    logic [15:0] x, y, out;
    logic [5:0]  ctl;
    logic in_valid, in_ready, out_valid, out_ready, zr, ng, co, ov;

    hack_alu_pipe #(.WIDTH(16), .FLAG_EXT(1)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .zx(ctl[5]), .nx(ctl[4]), .zy(ctl[3]), .ny(ctl[2]), .f(ctl[1]), .no(ctl[0]),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zr(zr), .ng(ng), .co(co), .ov(ov)
    );

    // ---------------- WIDTH=8 DUT ----------------
    logic [7:0] w8_x, w8_y, w8_out;
    logic [5:0] w8_c;
    logic w8_iv, w8_ir, w8_vld, w8_or, w8_zr, w8_ng, w8_co, w8_ovf;

    hack_alu_pipe #(.WIDTH(8), .FLAG_EXT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .x(w8_x), .y(w8_y),
        .zx(w8_c[5]), .nx(w8_c[4]), .zy(w8_c[3]), .ny(w8_c[2]), .f(w8_c[1]), .no(w8_c[0]),
        .in_valid(w8_iv), .in_ready(w8_ir), .out_valid(w8_vld), .out_ready(w8_or),
        .out(w8_out), .zr(w8_zr), .ng(w8_ng), .co(w8_co), .ov(w8_ovf)
    );

    // ---------------- WIDTH=32 DUT ----------------
    logic [31:0] w32_x, w32_y, w32_out;
    logic [5:0]  w32_c;
    logic w32_iv, w32_ir, w32_vld, w32_or, w32_zr, w32_ng, w32_co, w32_ovf;

    hack_alu_pipe #(.WIDTH(32), .FLAG_EXT(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .x(w32_x), .y(w32_y),
        .zx(w32_c[5]), .nx(w32_c[4]), .zy(w32_c[3]), .ny(w32_c[2]), .f(w32_c[1]), .no(w32_c[0]),
        .in_valid(w32_iv), .in_ready(w32_ir), .out_valid(w32_vld), .out_ready(w32_or),
        .out(w32_out), .zr(w32_zr), .ng(w32_ng), .co(w32_co), .ov(w32_ovf)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ndeliv = 0;
    bit lat_chk = 0;
    bit stall_prev = 0;
    logic [19:0] held;
    logic [19:0] exp_q[$];   // {co,ov,zr,ng,out}
    int          exp_t[$];   // acceptance cycle of each queued beat
    logic [15:0] canon_q[$]; // hand-written expected outs for the canonical sweep
    logic [5:0]  ops[18];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Reference: the Hack rules applied with plain wide arithmetic and a mask.
    // Returns {co, ov, zr, ng, out[63:0]}.
    function automatic logic [67:0] ref_alu(input int w, input logic [63:0] xi, input logic [63:0] yi,
                                            input logic [5:0] c);
        logic [63:0] mask, xp, yp, r, o;
        logic [64:0] s;
        logic cf, vf;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        xp = c[5] ? 64'd0 : (xi & mask);
        if (c[4]) xp = ~xp & mask;
        yp = c[3] ? 64'd0 : (yi & mask);
        if (c[2]) yp = ~yp & mask;
        cf = 1'b0;
        vf = 1'b0;
        if (c[1]) begin
            s  = {1'b0, xp} + {1'b0, yp};
            r  = s[63:0] & mask;
            cf = s[w];
            vf = (xp[w-1] == yp[w-1]) && (r[w-1] != xp[w-1]);
        end else begin
            r = xp & yp;
        end
        o = c[0] ? (~r & mask) : r;
        return {cf, vf, (o == 64'd0), o[w-1], o};
    endfunction

    function automatic logic [19:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic [5:0] c);
        logic [67:0] e;
        e = ref_alu(16, {48'd0, a}, {48'd0, b}, c);
        return {e[67:64], e[15:0]};
    endfunction

    // One clock of the WIDTH=16 driver plus scoreboard. Inputs change at the
    // falling edge; handshakes are evaluated 1 time unit later, ahead of the
    // rising edge where they take effect.
    task automatic step(input logic iv, input logic orr, input logic [15:0] xv, input logic [15:0] yv,
                        input logic [5:0] c, output logic acc);
        logic [19:0] got, e;
        int t;
        @(negedge clk);
        in_valid = iv; out_ready = orr; x = xv; y = yv; ctl = c;
        #1;
        cyc++;
        got = {co, ov, zr, ng, out};
        if (stall_prev) chk("hold", {44'd0, got}, {44'd0, held});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                t = exp_t.pop_front();
                chk("result", {44'd0, got}, {44'd0, e});
                if (lat_chk) chk("latency", 64'(cyc - t), 64'd2);
                if (canon_q.size() > 0) chk("canon", {48'd0, out}, {48'd0, canon_q.pop_front()});
                ndeliv++;
            end
        end
        stall_prev = out_valid && !out_ready;
        held = got;
        acc = in_valid && in_ready;
        if (acc) begin
            exp_q.push_back(ref16(xv, yv, c));
            exp_t.push_back(cyc);
        end
    endtask

    // Single-beat transactions on the narrow and wide instances.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [5:0] c);
        logic [67:0] e;
        @(negedge clk);
        w8_x = a; w8_y = b; w8_c = c; w8_iv = 1'b1; w8_or = 1'b1;
        #1 chk("w8_in_ready", {63'd0, w8_ir}, 64'd1);
        @(negedge clk);
        w8_iv = 1'b0;
        @(negedge clk);
        #1;
        e = ref_alu(8, {56'd0, a}, {56'd0, b}, c);
        chk("w8_valid", {63'd0, w8_vld}, 64'd1);
        chk("w8_res", {52'd0, w8_co, w8_ovf, w8_zr, w8_ng, w8_out}, {52'd0, e[67:64], e[7:0]});
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c);
        logic [67:0] e;
        @(negedge clk);
        w32_x = a; w32_y = b; w32_c = c; w32_iv = 1'b1; w32_or = 1'b1;
        #1 chk("w32_in_ready", {63'd0, w32_ir}, 64'd1);
        @(negedge clk);
        w32_iv = 1'b0;
        @(negedge clk);
        #1;
        e = ref_alu(32, {32'd0, a}, {32'd0, b}, c);
        chk("w32_valid", {63'd0, w32_vld}, 64'd1);
        chk("w32_res", {28'd0, w32_co, w32_ovf, w32_zr, w32_ng, w32_out}, {28'd0, e[67:64], e[31:0]});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic acc;
        logic [15:0] bx[5], by[5];
        logic [5:0]  bc[5];
        logic [19:0] first;
        int idx, nd0;

        ops = '{ZERO, ONE, NEG_ONE, X, Y, NOT_X, NOT_Y, NEG_X, NEG_Y,
                X_INC, Y_INC, X_DEC, Y_DEC, X_ADD_Y, X_SUB_Y, Y_SUB_X, X_AND_Y, X_OR_Y};
        in_valid = 0; out_ready = 0; x = 0; y = 0; ctl = 0;
        w8_iv = 0; w8_or = 0; w8_x = 0; w8_y = 0; w8_c = 0;
        w32_iv = 0; w32_or = 0; w32_x = 0; w32_y = 0; w32_c = 0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_outs", {44'd0, co, ov, zr, ng, out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Canonical sweep, x=2 y=3, back to back
        canon_q = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0002, 16'h0003, 16'hFFFD, 16'hFFFC, 16'hFFFE, 16'hFFFD,
                    16'h0003, 16'h0004, 16'h0001, 16'h0002, 16'h0005, 16'hFFFF, 16'h0001, 16'h0002, 16'h0003};
        lat_chk = 1;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b1, 16'd2, 16'd3, ops[i], acc);
            chk("sweep_accept", {63'd0, acc}, 64'd1);
        end
        repeat (2) step(1'b0, 1'b1, 16'd0, 16'd0, 6'd0, acc);
        chk("sweep_count", 64'(ndeliv), 64'd18);
        chk("canon_left", 64'(canon_q.size()), 64'd0);

        // Signed overflow and carry-out corners
        step(1'b1, 1'b1, 16'h7FFF, 16'h0001, X_ADD_Y, acc);
        repeat (2) step(1'b0, 1'b1, 16'd0, 16'd0, 6'd0, acc);
        chk("ovf_out", {44'd0, co, ov, zr, ng, out}, {44'd0, 4'b0101, 16'h8000});
        step(1'b1, 1'b1, 16'hFFFF, 16'h0001, X_ADD_Y, acc);
        repeat (2) step(1'b0, 1'b1, 16'd0, 16'd0, 6'd0, acc);
        chk("carry_out", {44'd0, co, ov, zr, ng, out}, {44'd0, 4'b1010, 16'h0000});
        lat_chk = 0;

        // Backpressure: five ops against a stalled consumer
        for (int i = 0; i < 5; i++) begin
            bx[i] = 16'($urandom); by[i] = 16'($urandom); bc[i] = ops[$urandom_range(17, 0)];
        end
        first = ref16(bx[0], by[0], bc[0]);
        idx = 0;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, bx[idx], by[idx], bc[idx], acc);
            if (acc) idx++;
        end
        chk("bp_accepts", 64'(idx), 64'd2);
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        chk("bp_first", {44'd0, co, ov, zr, ng, out}, {44'd0, first});
        out_ready = 1'b1;
        #1 chk("in_ready_from_out_ready", {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
        #1;
        nd0 = ndeliv;
        for (int k = 0; k < 20 && (ndeliv - nd0) < 5; k++) begin
            step(idx < 5, 1'b1, bx[idx % 5], by[idx % 5], bc[idx % 5], acc);
            if (acc) idx++;
        end
        chk("bp_delivered", 64'(ndeliv - nd0), 64'd5);

        // Reset with two results in flight
        step(1'b1, 1'b0, 16'h1234, 16'h0F0F, X_OR_Y, acc);
        step(1'b1, 1'b0, 16'h0001, 16'h0002, X_ADD_Y, acc);
        @(negedge clk);
        in_valid = 0; out_ready = 0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_outs", {44'd0, co, ov, zr, ng, out}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        exp_q.delete();
        exp_t.delete();
        stall_prev = 0;
        repeat (4) step(1'b0, 1'b1, 16'd0, 16'd0, 6'd0, acc);

        // Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            logic [5:0] c;
            c = ($urandom_range(1, 0) == 1) ? ops[$urandom_range(17, 0)] : 6'($urandom);
            step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                 16'($urandom), 16'($urandom), c, acc);
        end
        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            step(1'b0, 1'b1, 16'd0, 16'd0, 6'd0, acc);
        chk("drain", 64'(exp_q.size()), 64'd0);

        // Narrow and wide instances
        run8(8'd5, 8'd7, X_SUB_Y);
        chk("w8_sub", {55'd0, w8_ng, w8_out}, {55'd0, 1'b1, 8'hFE});
        run32(32'hFFFF_FFFF, 32'd0, X_INC);
        chk("w32_inc", {31'd0, w32_zr, w32_out}, {31'd0, 1'b1, 32'd0});
        for (int k = 0; k < 6; k++) begin
            run8(8'($urandom), 8'($urandom), ops[$urandom_range(17, 0)]);
            run32($urandom, $urandom, ops[$urandom_range(17, 0)]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: a stuck run still produces its summary.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout got=%0d want=%0d", cyc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hack_alu_pipe.md
HACK_ALU_PIPE -- requirements
Module: hack_alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data width of x, y and out; legal range 4..64.
REQ-002 The block SHALL have parameter FLAG_EXT, default 1, meaning 1 enables the co/ov flag logic and 0 ties co and ov to 0.
REQ-003 Port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port x, input, WIDTH bits: operand x.
REQ-006 Port y, input, WIDTH bits: operand y.
REQ-007 Ports zx, nx, zy, ny, f, no, input, 1 bit each: Hack control bits, with the same meaning as the combinational Hack ALU.
REQ-008 Port in_valid, input, 1 bit: operands and control are valid.
REQ-009 Port in_ready, output, 1 bit: block accepts input this cycle.
REQ-010 Port out_valid, output, 1 bit: out and flags are valid.
REQ-011 Port out_ready, input, 1 bit: consumer accepts output this cycle.
REQ-012 Port out, output, WIDTH bits: result.
REQ-013 Ports zr and ng, output, 1 bit each: zr = (out == 0); ng = out MSB.
REQ-014 Ports co and ov, output, 1 bit each: co = carry out of the adder MSB; ov = two's-complement overflow of the adder.

Function
REQ-015 Input transfer SHALL occur iff in_valid && in_ready; output transfer SHALL occur iff out_valid && out_ready.
REQ-016 Stage 1 SHALL register the preset operands and f/no: xp = zx ? 0 : x, then nx ? ~xp : xp; yp likewise with zy/ny.
REQ-017 Stage 2 SHALL compute r = f ? xp + yp (mod 2^WIDTH) : xp & yp, then out = no ? ~r : r, and register out, zr, ng, co and ov.
REQ-018 Latency SHALL be exactly 2 cycles: a transfer at edge N with out_ready held high gives out_valid at edge N+2.
REQ-019 Throughput SHALL be one result per cycle while out_ready = 1.
REQ-020 co and ov SHALL be computed on r before the no inversion; both SHALL be 0 when f = 0 or FLAG_EXT = 0.
REQ-021 ov SHALL be 1 iff xp and yp have the same MSB and the MSB of r differs from it.
REQ-022 zr and ng SHALL be computed on the final out, after no.
REQ-023 Stage 2 SHALL load iff !s2_valid || out_ready.
REQ-024 Stage 1 SHALL advance iff !s1_valid || stage-2 load.
REQ-025 in_ready SHALL equal the stage-1 advance condition and SHALL be combinational from out_ready, with no combinational path from in_valid.
REQ-026 Backpressure: while out_valid && !out_ready, out and all flags SHALL hold stable, and the pipe SHALL accept at most one more operand, after which in_ready = 0.
REQ-027 Simultaneous input and output transfer on a full pipe SHALL lose and duplicate no result.
REQ-028 Results SHALL emerge in strict input order.
REQ-029 The adder SHALL wrap modulo 2^WIDTH, with no saturation.
REQ-030 Inputs SHALL be ignored when in_ready = 0.

Reset
REQ-031 When rst_n = 0 at a clock edge, s1_valid, s2_valid and out_valid SHALL be 0, and out, zr, ng, co and ov SHALL be 0.
REQ-032 in_ready SHALL be 1 in the first cycle after rst_n is released.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight results, with no output transfer in the reset cycle.

Structure
REQ-034 Package hack_alu_pkg SHALL hold localparams for the 18 canonical Hack control encodings (ZERO, ONE, NEG_ONE, X, Y, NOT_X, NOT_Y, NEG_X, NEG_Y, X_INC, Y_INC, X_DEC, Y_DEC, X_ADD_Y, X_SUB_Y, Y_SUB_X, X_AND_Y, X_OR_Y) as 6-bit {zx,nx,zy,ny,f,no}.
REQ-035 Sub-module hack_alu_core SHALL be the purely combinational WIDTH-parametrised stage-2 datapath (r, out, flags) and SHALL be instantiated once.

Verification
REQ-036 WIDTH=16, x=2, y=3, all 18 canonical ops, out_ready=1 -> outputs in order 0, 1, -1, 2, 3, 0xFFFD, 0xFFFC, 0xFFFE, 0xFFFD, 3, 4, 1, 2, 5, 0xFFFF, 1, 2, 3, each 2 cycles after its input, one per cycle.
REQ-037 x=0x7FFF, y=1, X_ADD_Y -> out=0x8000, ng=1, ov=1, co=0; x=0xFFFF, y=1 -> out=0, zr=1, co=1, ov=0.
REQ-038 Stream 5 ops with out_ready=0 -> in_ready drops after 2 accepts and out holds the first result; release out_ready -> all 5 results delivered in order with no duplicates.
REQ-039 rst_n=0 for one cycle with 2 results in flight -> out_valid=0 and outputs 0 the next cycle, and no stale result appears afterwards.
REQ-040 WIDTH=8, X_SUB_Y, x=5, y=7 -> out=0xFE, ng=1; WIDTH=32, X_INC, x=0xFFFFFFFF -> out=0, zr=1.
